score_scheduler: RTL

Sequences the two-lane BCD score counter of the Dino game. It runs the game state machine (idle, clear, run, over) and generates one-cycle score-increment pulses per lane from an internal prescaler. It latches per-lane crashes, decides the winner, and keeps a BCD high score. It sits between the collision logic and the score counter, and replaces free-running clock-divider ticking with single-clock enables.

---
 rtl/score_scheduler.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/score_scheduler.sv
// score_scheduler: game sequencer for the two-lane BCD score counter of the Dino game.
// It runs the IDLE/CLEAR/RUN/OVER state machine and issues one-cycle per-lane
// score-increment enables from an internal prescaler instead of a divided clock.
// It also latches per-lane crashes, decides the winner and keeps a BCD high score.
//
// Optional feature: define SCORE_SPEEDUP_EN to shorten the tick period as the
// hundreds digit of the leading lane grows (P = TICK_DIV >> min(3, hundreds)).
//
// Ports
//   clk         system clock, rising edge
//   rst         synchronous active-high reset
//   start       one-cycle start/restart request
//   crash[1:0]  per-lane collision level (bit0 lane 0, bit1 lane 1)
//   score_data  counter value, [15:0] lane 0, [31:16] lane 1 (4 BCD digits each)
//   score_clr   one-cycle counter clear pulse (during CLEAR)
//   score_inc   one-cycle per-lane increment pulse
//   state       00 IDLE, 01 CLEAR, 10 RUN, 11 OVER
//   crashed     sticky per-lane crash latch
//   winner      01 lane 0, 10 lane 1, 11 tie, 00 undecided
//   hi_score    BCD high score, 4 digits
module score_scheduler #(
    parameter int unsigned TICK_DIV = 16777216,
    parameter int unsigned TICK_W   = 25
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [1:0]  crash,
    input  logic [31:0] score_data,
    output logic        score_clr,
    output logic [1:0]  score_inc,
    output logic [1:0]  state,
    output logic [1:0]  crashed,
    output logic [1:0]  winner,
    output logic [15:0] hi_score
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_CLEAR = 2'b01,
        S_RUN   = 2'b10,
        S_OVER  = 2'b11
    } state_t;

    state_t            cur_state;
    state_t            nxt_state;
    logic [TICK_W-1:0] presc;
    logic [TICK_W-1:0] period;
    logic              tick;
    logic [1:0]        eff;
    logic              first_over;
    logic [15:0]       lane_max;

`ifdef SCORE_SPEEDUP_EN
    logic [1:0] lvl;
    logic [1:0] lvl_new;
    logic [3:0] hund;

    // Speed level from the larger hundreds digit, saturated at 3.
    always_comb begin
        hund    = (score_data[11:8] > score_data[27:24]) ? score_data[11:8] : score_data[27:24];
        lvl_new = (hund > 4'd3) ? 2'd3 : hund[1:0];
        period  = TICK_W'(TICK_DIV) >> lvl;
    end
`else
    always_comb period = TICK_W'(TICK_DIV);
`endif

    // Tick on the last count of the current period; crashes gate lanes in the same cycle.
    assign tick     = (cur_state == S_RUN) && (presc == (period - TICK_W'(1)));
    assign eff      = crashed | crash;
    assign lane_max = (score_data[15:0] > score_data[31:16]) ? score_data[15:0] : score_data[31:16];
    assign state    = cur_state;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) cur_state <= S_IDLE;
        else     cur_state <= nxt_state;
    end

    // Next-state and decoded pulse outputs.
    always_comb begin
        nxt_state = cur_state;
        score_clr = 1'b0;
        score_inc = 2'b00;
        case (cur_state)
            S_IDLE: begin
                if (start) nxt_state = S_CLEAR;
            end
            S_CLEAR: begin
                score_clr = 1'b1;
                nxt_state = S_RUN;
            end
            S_RUN: begin
                if (tick) score_inc = ~eff;
                if (eff == 2'b11) nxt_state = S_OVER;
            end
            S_OVER: begin
                if (start) nxt_state = S_CLEAR;
            end
            default: nxt_state = S_IDLE;
        endcase
    end

    // Prescaler, crash latch, winner and high score.
    always_ff @(posedge clk) begin
        if (rst) begin
            presc      <= '0;
            crashed    <= 2'b00;
            winner     <= 2'b00;
            hi_score   <= 16'h0000;
            first_over <= 1'b0;
`ifdef SCORE_SPEEDUP_EN
            lvl        <= 2'd0;
`endif
        end else begin
            first_over <= (cur_state == S_RUN) && (nxt_state == S_OVER);
            case (cur_state)
                S_CLEAR: begin
                    presc   <= '0;
                    crashed <= 2'b00;
                    winner  <= 2'b00;
`ifdef SCORE_SPEEDUP_EN
                    lvl     <= 2'd0;
`endif
                end
                S_RUN: begin
                    presc   <= tick ? '0 : presc + TICK_W'(1);
                    crashed <= eff;
`ifdef SCORE_SPEEDUP_EN
                    if (tick) lvl <= lvl_new;
`endif
                    // Lane that was already latched crashed first, so the other one wins.
                    if (eff == 2'b11)
                        winner <= (crashed == 2'b00) ? 2'b11 : ~crashed;
                end
                S_OVER: begin
                    if (first_over && (lane_max > hi_score)) hi_score <= lane_max;
                end
                default: ;
            endcase
        end
    end

endmodule
